// File: rtl/lcd_bus_if.sv
// lcd_bus_if
//  Bundles the two byte-requester handshakes and the HD44780 write bus that
//  lcd_bus_arbiter owns.
//  Requester n (n = 0, 1):
//    reqn   requester has a byte; held with rsn/datan/lockn stable until ackn
//    rsn    register select for the byte (0 = command, 1 = data)
//    datan  the byte
//    lockn  keep the bus for this requester's next byte
//    ackn   1-cycle pulse from the arbiter when the byte is accepted
//  LCD bus and status (driven by the arbiter):
//    rs, rw, enable, data   HD44780 write-side pins (rw always 0)
//    init_done              power-up init sequence has completed
//    busy                   arbiter is not idle
//  Modports: master = the arbiter, slave = requesters / bus observers.
interface lcd_bus_if;
  logic       req0;
  logic       rs0;
  logic [7:0] data0;
  logic       lock0;
  logic       ack0;
  logic       req1;
  logic       rs1;
  logic [7:0] data1;
  logic       lock1;
  logic       ack1;
  logic       rs;
  logic       rw;
  logic       enable;
  logic [7:0] data;
  logic       init_done;
  logic       busy;

  modport master (
    input  req0, rs0, data0, lock0,
    input  req1, rs1, data1, lock1,
    output ack0, ack1,
    output rs, rw, enable, data, init_done, busy
  );

  modport slave (
    output req0, rs0, data0, lock0,
    output req1, rs1, data1, lock1,
    input  ack0, ack1,
    input  rs, rw, enable, data, init_done, busy
  );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter
//  Sole owner of the HD44780 write bus. After reset it waits POWERUP_CYCLES,
//  writes the init bytes 38/0C/01/06 (rs=0), then shares the bus round-robin
//  between requester 0 (face/figure engine) and requester 1 (status/sleep
//  engine), with an optional lock that lets one requester keep the bus.
//  Every byte is written as SETUP (1 cycle) -> PULSE (enable high
//  ENABLE_CYCLES) -> WAIT (CMD_WAIT_CYCLES, or CLEAR_WAIT_CYCLES for the
//  clear/home commands).
//  Ports:
//    clk    system clock
//    reset  synchronous, active-high reset
//    bus    lcd_bus_if.master: requester handshakes in, acks and LCD bus out
module lcd_bus_arbiter #(
  parameter int POWERUP_CYCLES    = 2500000,
  parameter int ENABLE_CYCLES     = 25,
  parameter int CMD_WAIT_CYCLES   = 2500,
  parameter int CLEAR_WAIT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  lcd_bus_if.master  bus
);

  localparam int MAX_AB = (POWERUP_CYCLES > ENABLE_CYCLES) ? POWERUP_CYCLES : ENABLE_CYCLES;
  localparam int MAX_CD = (CMD_WAIT_CYCLES > CLEAR_WAIT_CYCLES) ? CMD_WAIT_CYCLES : CLEAR_WAIT_CYCLES;
  localparam int MAX_CYCLES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W = $clog2(MAX_CYCLES) + 1;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_SETUP,
    ST_PULSE,
    ST_WAIT,
    ST_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       init_idx_q, init_idx_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             enable_q, enable_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             init_done_q, init_done_d;
  logic             busy_q, busy_d;
  logic             rr_q, rr_d;
  logic             owner_valid_q, owner_valid_d;
  logic             owner_q, owner_d;

  logic [1:0] req_vec;
  logic [1:0] rs_vec;
  logic [1:0] lock_vec;
  logic       grant_valid;
  logic       grant_id;
  logic       long_wait;

  assign req_vec  = {bus.req1, bus.req0};
  assign rs_vec   = {bus.rs1, bus.rs0};
  assign lock_vec = {bus.lock1, bus.lock0};

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = 8'h38;
      2'd1:    b = 8'h0C;
      2'd2:    b = 8'h01;
      default: b = 8'h06;
    endcase
    return b;
  endfunction

  // Clear display (01) and return home (02) need the long post-pulse wait.
  assign long_wait = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02));

  // A lock owner excludes the other side even while the owner's req is low.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (owner_valid_q) begin
      grant_id    = owner_q;
      grant_valid = req_vec[owner_q];
    end else if (req_vec[0] && req_vec[1]) begin
      grant_id    = rr_q;
      grant_valid = 1'b1;
    end else if (req_vec[0]) begin
      grant_id    = 1'b0;
      grant_valid = 1'b1;
    end else if (req_vec[1]) begin
      grant_id    = 1'b1;
      grant_valid = 1'b1;
    end
  end

  // The counter is reloaded with (length - 1) on every state entry and the
  // state is left on the cycle it reads zero, so each state lasts exactly
  // its length.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    init_idx_d    = init_idx_q;
    rs_d          = rs_q;
    data_d        = data_q;
    enable_d      = enable_q;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;
    init_done_d   = init_done_q;
    rr_d          = rr_q;
    owner_valid_d = owner_valid_q;
    owner_d       = owner_q;

    case (state_q)
      ST_POWERUP: begin
        if (cnt_q == '0) begin
          state_d    = ST_SETUP;
          cnt_d      = '0;
          init_idx_d = 2'd0;
          rs_d       = 1'b0;
          data_d     = init_byte(2'd0);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_SETUP: begin
        state_d  = ST_PULSE;
        cnt_d    = CNT_W'(ENABLE_CYCLES - 1);
        enable_d = 1'b1;
      end

      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d  = ST_WAIT;
          enable_d = 1'b0;
          cnt_d    = long_wait ? CNT_W'(CLEAR_WAIT_CYCLES - 1)
                               : CNT_W'(CMD_WAIT_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_WAIT: begin
        if (cnt_q == '0) begin
          cnt_d = '0;
          if (!init_done_q && (init_idx_q != 2'd3)) begin
            state_d    = ST_SETUP;
            init_idx_d = init_idx_q + 2'd1;
            rs_d       = 1'b0;
            data_d     = init_byte(init_idx_q + 2'd1);
          end else begin
            state_d     = ST_IDLE;
            init_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_IDLE: begin
        cnt_d = '0;
        if (grant_valid) begin
          state_d = ST_SETUP;
          rs_d    = rs_vec[grant_id];
          data_d  = grant_id ? bus.data1 : bus.data0;
          ack0_d  = !grant_id;
          ack1_d  = grant_id;
          if (lock_vec[grant_id]) begin
            owner_valid_d = 1'b1;
            owner_d       = grant_id;
          end else begin
            owner_valid_d = 1'b0;
            rr_d          = !grant_id;
          end
        end
      end

      default: begin
        state_d = ST_POWERUP;
        cnt_d   = CNT_W'(POWERUP_CYCLES - 1);
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_POWERUP;
      cnt_q         <= CNT_W'(POWERUP_CYCLES - 1);
      init_idx_q    <= 2'd0;
      rs_q          <= 1'b0;
      data_q        <= 8'h00;
      enable_q      <= 1'b0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      init_done_q   <= 1'b0;
      busy_q        <= 1'b1;
      rr_q          <= 1'b0;
      owner_valid_q <= 1'b0;
      owner_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      init_idx_q    <= init_idx_d;
      rs_q          <= rs_d;
      data_q        <= data_d;
      enable_q      <= enable_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
      init_done_q   <= init_done_d;
      busy_q        <= busy_d;
      rr_q          <= rr_d;
      owner_valid_q <= owner_valid_d;
      owner_q       <= owner_d;
    end
  end

  assign bus.rs        = rs_q;
  assign bus.rw        = 1'b0;
  assign bus.enable    = enable_q;
  assign bus.data      = data_q;
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.init_done = init_done_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter
//  Directed bench for lcd_bus_arbiter with shortened timing. Expected LCD
//  writes (source, rs, data, post-pulse wait) are queued when stimulus is
//  driven; a monitor pops one entry per enable pulse and checks it, plus the
//  pulse width, the post-pulse wait and the ack rules.
module tb_lcd_bus_arbiter;
  localparam int P_PU  = 20;
  localparam int P_EN  = 3;
  localparam int P_CMD = 5;
  localparam int P_CLR = 12;
  localparam int SRC_NONE = 2;

  typedef struct {
    int         src;
    logic       rs;
    logic [7:0] data;
    int         wt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  lcd_bus_if bus();

  always #5 clk = ~clk;

  lcd_bus_arbiter #(
    .POWERUP_CYCLES   (P_PU),
    .ENABLE_CYCLES    (P_EN),
    .CMD_WAIT_CYCLES  (P_CMD),
    .CLEAR_WAIT_CYCLES(P_CLR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  bit   in_wait = 0;

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic void push_exp(input int src, input logic rs_i, input logic [7:0] d);
    exp_t e;
    e.src  = src;
    e.rs   = rs_i;
    e.data = d;
    e.wt   = (!rs_i && (d == 8'h01 || d == 8'h02)) ? P_CLR : P_CMD;
    sb.push_back(e);
  endfunction

  function automatic void push_init();
    push_exp(SRC_NONE, 1'b0, 8'h38);
    push_exp(SRC_NONE, 1'b0, 8'h0C);
    push_exp(SRC_NONE, 1'b0, 8'h01);
    push_exp(SRC_NONE, 1'b0, 8'h06);
  endfunction

  task automatic wait_ack(input int who);
    bit got;
    got = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if ((who == 0) ? bus.ack0 : bus.ack1) begin
        got = 1;
        break;
      end
    end
    check((who == 0) ? "ack0_wait" : "ack1_wait", int'(got), 1);
  endtask

  task automatic drive(input int who, input logic rs_i, input logic [7:0] d,
                       input logic lk, input logic keep);
    if (who == 0) begin
      bus.rs0 = rs_i; bus.data0 = d; bus.lock0 = lk; bus.req0 = 1'b1;
    end else begin
      bus.rs1 = rs_i; bus.data1 = d; bus.lock1 = lk; bus.req1 = 1'b1;
    end
    wait_ack(who);
    if (!keep) begin
      if (who == 0) bus.req0 = 1'b0;
      else          bus.req1 = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    bit got;
    got = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !in_wait && !bus.busy && !bus.enable) begin
        got = 1;
        break;
      end
    end
    check(tag, int'(got), 1);
  endtask

  initial begin
    int k;
    bit got;

    bus.req0 = 1'b0; bus.rs0 = 1'b0; bus.data0 = 8'h00; bus.lock0 = 1'b0;
    bus.req1 = 1'b0; bus.rs1 = 1'b0; bus.data1 = 8'h00; bus.lock1 = 1'b0;

    // Monitor: one enable pulse = one LCD write transaction.
    fork
      begin : monitor
        logic en_prev, a0p, a1p;
        int   pulse_cnt, wait_cnt, cur_wait, src;
        exp_t e;
        en_prev = 1'b0; a0p = 1'b0; a1p = 1'b0;
        pulse_cnt = 0; wait_cnt = 0; cur_wait = 0;
        forever begin
          @(negedge clk);
          if (reset) begin
            in_wait = 0;
            en_prev = 1'b0;
            a0p     = 1'b0;
            a1p     = 1'b0;
          end else begin
            if (a0p || a1p) check("ack_width", int'({bus.ack0, bus.ack1}), 0);
            if (bus.ack0 || bus.ack1) check("ack_before_init_done", int'(bus.init_done), 1);
            if (in_wait && !bus.enable) begin
              if (bus.busy) wait_cnt++;
              else begin
                check("wait_len", wait_cnt, cur_wait);
                in_wait = 0;
              end
            end
            if (bus.enable && !en_prev) begin
              // Count reached here includes the next byte's SETUP cycle.
              if (in_wait) begin
                check("wait_len", wait_cnt - 1, cur_wait);
                in_wait = 0;
              end
              check("pulse_expected", int'(sb.size() != 0), 1);
              src = a0p ? 0 : (a1p ? 1 : SRC_NONE);
              if (sb.size() != 0) begin
                e = sb.pop_front();
                check("write_src", src, e.src);
                check("write_rs", int'(bus.rs), int'(e.rs));
                check("write_data", int'(bus.data), int'(e.data));
                cur_wait = e.wt;
                $display("write: src=%0d rs=%0d data=%02h", src, bus.rs, bus.data);
              end
              check("write_rw", int'(bus.rw), 0);
              pulse_cnt = 1;
            end else if (bus.enable) begin
              pulse_cnt++;
            end
            if (!bus.enable && en_prev) begin
              check("pulse_len", pulse_cnt, P_EN);
              in_wait  = 1;
              wait_cnt = 1;
            end
            en_prev = bus.enable;
            a0p     = bus.ack0;
            a1p     = bus.ack1;
          end
        end
      end
    join_none

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_rs", int'(bus.rs), 0);
    check("rst_rw", int'(bus.rw), 0);
    check("rst_enable", int'(bus.enable), 0);
    check("rst_data", int'(bus.data), 0);
    check("rst_ack0", int'(bus.ack0), 0);
    check("rst_ack1", int'(bus.ack1), 0);
    check("rst_init_done", int'(bus.init_done), 0);
    check("rst_busy", int'(bus.busy), 1);

    // Test 1: init sequence with no requests.
    push_init();
    reset = 1'b0;
    k = 0;
    got = 0;
    for (int n = 1; n <= 500; n++) begin
      @(negedge clk);
      if (bus.init_done) begin
        k = n;
        got = 1;
        break;
      end
    end
    check("init_done_seen", int'(got), 1);
    check("init_cycles", k, P_PU + 4 * (1 + P_EN) + 3 * P_CMD + P_CLR);
    check("init_busy", int'(bus.busy), 0);
    wait_idle("t1_idle");

    // Test 2: single data byte from requester 0.
    push_exp(0, 1'b1, 8'h41);
    drive(0, 1'b1, 8'h41, 1'b0, 1'b0);
    wait_idle("t2_idle");

    // Test 5: clear command gets the long wait, same byte as data does not.
    push_exp(1, 1'b0, 8'h01);
    drive(1, 1'b0, 8'h01, 1'b0, 1'b0);
    wait_idle("t5a_idle");
    push_exp(1, 1'b1, 8'h01);
    drive(1, 1'b1, 8'h01, 1'b0, 1'b0);
    wait_idle("t5b_idle");

    // Test 3: both requesters, no lock, 4 bytes each: strict alternation from 0.
    for (int i = 0; i < 4; i++) begin
      push_exp(0, 1'b1, 8'hA0 + 8'(i));
      push_exp(1, 1'b1, 8'hB0 + 8'(i));
    end
    fork
      for (int i = 0; i < 4; i++) drive(0, 1'b1, 8'hA0 + 8'(i), 1'b0, i < 3);
      for (int j = 0; j < 4; j++) drive(1, 1'b1, 8'hB0 + 8'(j), 1'b0, j < 3);
    join
    wait_idle("t3_idle");

    // Test 4: requester 0 locks for two bytes, releases on the third.
    push_exp(0, 1'b1, 8'hC0);
    push_exp(0, 1'b1, 8'hC1);
    push_exp(0, 1'b1, 8'hC2);
    push_exp(1, 1'b1, 8'hD0);
    fork
      begin
        drive(0, 1'b1, 8'hC0, 1'b1, 1'b1);
        drive(0, 1'b1, 8'hC1, 1'b1, 1'b1);
        drive(0, 1'b1, 8'hC2, 1'b0, 1'b0);
      end
      drive(1, 1'b1, 8'hD0, 1'b0, 1'b0);
    join
    wait_idle("t4_idle");

    // Test 6: reset while enable is high.
    push_exp(0, 1'b1, 8'h55);
    bus.rs0 = 1'b1; bus.data0 = 8'h55; bus.lock0 = 1'b0; bus.req0 = 1'b1;
    wait_ack(0);
    @(negedge clk);
    @(negedge clk);
    check("t6_enable_before", int'(bus.enable), 1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_enable", int'(bus.enable), 0);
    check("t6_init_done", int'(bus.init_done), 0);
    check("t6_busy", int'(bus.busy), 1);
    check("t6_ack0", int'(bus.ack0), 0);
    @(negedge clk);
    push_init();
    push_exp(0, 1'b1, 8'h55);
    reset = 1'b0;
    wait_ack(0);
    bus.req0 = 1'b0;
    wait_idle("t6_idle");

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
